bcd_adder_seq: RTL

//  Digit-serial, multi-digit BCD adder. Adds two packed BCD operands one digit per clock, LSD first.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_adder_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the digit-serial BCD adder.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal carry; combinational, reused every ADD cycle.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    logic [DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        if (raw > {1'b0, BCD_MAX}) begin
            s  = raw[DIGIT_W-1:0] + BCD_CORR;
            co = 1'b1;
        end else begin
            s  = raw[DIGIT_W-1:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_adder_seq.sv
// Digit-serial multi-digit BCD adder, LSD first, start/busy/done handshake.
// Optional invalid-digit flag on err when BCD_INVALID_CHECK_EN is defined.
module bcd_adder_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] A,
    input  logic [DIGIT_W*DIGITS-1:0] B,
    input  logic                      Cin,
    output logic [DIGIT_W*DIGITS-1:0] S,
    output logic                      Cout,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_sh, b_sh, res_sh, res_nxt;
    logic               carry;
    logic [DIGIT_W-1:0] sum_d;
    logic               sum_co;
    logic               accept, last_add;

    bcd_digit_add u_digit (
        .a  (a_sh[DIGIT_W-1:0]),
        .b  (b_sh[DIGIT_W-1:0]),
        .ci (carry),
        .s  (sum_d),
        .co (sum_co)
    );

    assign accept   = (state == IDLE) && start;
    assign last_add = (state == ADD) && (idx == LAST);
    // New digit enters at the MSD end; the final edge writes the completed word straight to S.
    assign res_nxt  = W'({sum_d, res_sh} >> DIGIT_W);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            idx    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            S      <= '0;
            Cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh   <= A;
                b_sh   <= B;
                carry  <= Cin;
                idx    <= '0;
                res_sh <= '0;
            end else if (state == ADD) begin
                a_sh   <= a_sh >> DIGIT_W;
                b_sh   <= b_sh >> DIGIT_W;
                carry  <= sum_co;
                res_sh <= res_nxt;
                idx    <= idx + 1'b1;
                if (last_add) begin
                    S    <= res_nxt;
                    Cout <= sum_co;
                end
            end
        end
    end

`ifdef BCD_INVALID_CHECK_EN
    logic err_sticky;
    logic bad_now;

    assign bad_now = digit_invalid(a_sh[DIGIT_W-1:0]) | digit_invalid(b_sh[DIGIT_W-1:0]);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            err_sticky <= 1'b0;
            err        <= 1'b0;
        end else if (accept) begin
            err_sticky <= 1'b0;
            err        <= 1'b0;
        end else if (state == ADD) begin
            err_sticky <= err_sticky | bad_now;
            if (last_add) err <= err_sticky | bad_now;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
